// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// mac_pkg : shared width defaults and arithmetic helpers for the mac_pe tile
// Rev 1.0
// ============================================================================
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int MAX_W      = 64;

  typedef logic [MAX_W-1:0] word_t;
  typedef logic [MAX_W:0]   wide_t;

  typedef struct packed {
    word_t sum;
    logic  ovf;
  } sat_res_t;

  // Only the low w bits of a and b are meaningful; the sum is returned in w bits.
  function automatic sat_res_t sat_add(input word_t a, input word_t b, input logic is_signed,
                                       input logic sat_en, input int unsigned w);
    wide_t    msb;
    wide_t    mask;
    wide_t    raw;
    logic     sa, sb, sr;
    sat_res_t r;
    msb   = wide_t'(1) << (w - 1);
    mask  = (msb << 1) - wide_t'(1);
    raw   = ({1'b0, a} & mask) + ({1'b0, b} & mask);
    sa    = |({1'b0, a} & msb);
    sb    = |({1'b0, b} & msb);
    sr    = |(raw & msb);
    r.ovf = is_signed ? ((sa == sb) && (sr != sa)) : |(raw & (msb << 1));
    r.sum = raw[MAX_W-1:0] & mask[MAX_W-1:0];
    if (r.ovf && sat_en) begin
      if (!is_signed)
        r.sum = mask[MAX_W-1:0];
      else if (sa)
        r.sum = msb[MAX_W-1:0];
      else
        r.sum = mask[MAX_W-1:0] >> 1;
    end
    return r;
  endfunction

  // Extends a pw-bit product held in the low bits of p to the full word.
  function automatic word_t ext_prod(input word_t p, input logic is_signed, input int unsigned pw);
    word_t msb;
    word_t low;
    msb = word_t'(1) << (pw - 1);
    low = (msb << 1) - word_t'(1);
    if (is_signed && |(p & msb))
      return p | ~low;
    return p & low;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_acc_stage.sv
`default_nettype none
// ============================================================================
// mac_acc_stage : accumulate stage with saturation, sticky flag, term counter
// Rev 1.0
// ============================================================================
module mac_acc_stage
  import mac_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                v1_i,
  input  logic                first1_i,
  input  logic                last1_i,
  input  logic                signed1_i,
  input  logic [2*DATA_W-1:0] p1_i,
  output logic [ACC_W-1:0]    acc_o,
  output logic                result_valid_o,
  output logic                sat_flag_o,
  output logic [CNT_W-1:0]    term_count_o
);

  localparam bit SAT_EN = (SATURATE != 0);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rv_q;
  word_t            w_ext;
  sat_res_t         w_sum;
  logic             w_unused;

  always_comb begin
    w_ext = ext_prod(word_t'(p1_i), signed1_i, 2 * DATA_W);
    w_sum = sat_add(word_t'(acc_q), w_ext, signed1_i, SAT_EN, ACC_W);
    acc_d = acc_q;
    sat_d = sat_q;
    cnt_d = cnt_q;
    if (v1_i) begin
      if (first1_i) begin
        acc_d = w_ext[ACC_W-1:0];
        sat_d = 1'b0;
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = w_sum.sum[ACC_W-1:0];
        sat_d = sat_q | (w_sum.ovf & SAT_EN);
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Upper word bits beyond ACC_W are don't-care by construction.
  assign w_unused = &{1'b0, w_ext, w_sum};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
      rv_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
      rv_q  <= v1_i & last1_i;
    end
  end

  assign acc_o          = acc_q;
  assign sat_flag_o     = sat_q;
  assign term_count_o   = cnt_q;
  assign result_valid_o = rv_q;

endmodule
`default_nettype wire

// File: rtl/mac_pe.sv
`default_nettype none
// ============================================================================
// mac_pe : pipelined systolic multiply-accumulate tile (operand/multiply/acc)
// Rev 1.0
// ============================================================================
module mac_pe
  import mac_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              first,
  input  logic              last,
  input  logic              signed_mode,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              pass_valid,
  output logic              pass_first,
  output logic              pass_last,
  output logic              pass_signed,
  output logic [ACC_W-1:0]  acc_out,
  output logic              result_valid,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  term_count
);

  logic [DATA_W-1:0]   a_q, b_q;
  logic                pv_q, pf_q, pl_q, ps_q;
  logic [2*DATA_W-1:0] p1_q;
  logic                v1_q, f1_q, l1_q, s1_q;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_sx_a, w_sx_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      pv_q <= 1'b0;
      pf_q <= 1'b0;
      pl_q <= 1'b0;
      ps_q <= 1'b0;
    end else begin
      pv_q <= in_valid;
      if (in_valid) begin
        a_q  <= a_in;
        b_q  <= b_in;
        pf_q <= first;
        pl_q <= last;
        ps_q <= signed_mode;
      end
    end
  end

  // One multiplier serves both modes: operands are widened per mode before multiplying.
  always_comb begin
    w_sx_a = ps_q & a_q[DATA_W-1];
    w_sx_b = ps_q & b_q[DATA_W-1];
    w_prod = {{DATA_W{w_sx_a}}, a_q} * {{DATA_W{w_sx_b}}, b_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q <= '0;
      v1_q <= 1'b0;
      f1_q <= 1'b0;
      l1_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      v1_q <= pv_q;
      if (pv_q) begin
        p1_q <= w_prod;
        f1_q <= pf_q;
        l1_q <= pl_q;
        s1_q <= ps_q;
      end
    end
  end

  mac_acc_stage #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .CNT_W    (CNT_W),
    .SATURATE (SATURATE)
  ) u_acc (
    .clk            (clk),
    .reset          (reset),
    .v1_i           (v1_q),
    .first1_i       (f1_q),
    .last1_i        (l1_q),
    .signed1_i      (s1_q),
    .p1_i           (p1_q),
    .acc_o          (acc_out),
    .result_valid_o (result_valid),
    .sat_flag_o     (sat_flag),
    .term_count_o   (term_count)
  );

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign pass_valid  = pv_q;
  assign pass_first  = pf_q;
  assign pass_last   = pl_q;
  assign pass_signed = ps_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_pe.sv
`default_nettype none
// ============================================================================
// tb_mac_pe : directed vectors on three mac_pe configurations, checked against
//             an integer-arithmetic model plus hand-computed expectations
// Rev 1.0
// ============================================================================
module tb_mac_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, in_valid = 1'b0, first = 1'b0, last = 1'b0, signed_mode = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;

  logic [7:0]  a_o [3];
  logic [7:0]  b_o [3];
  logic        pv_o [3], pf_o [3], pl_o [3], ps_o [3], rv_o [3], sat_o [3];
  logic [15:0] cnt_o [3];
  logic [31:0] acc32;
  logic [15:0] acc16s, acc16w;

  mac_pe #(.DATA_W(8), .ACC_W(32), .CNT_W(16), .SATURATE(1)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .first(first), .last(last), .signed_mode(signed_mode),
    .a_out(a_o[0]), .b_out(b_o[0]), .pass_valid(pv_o[0]), .pass_first(pf_o[0]),
    .pass_last(pl_o[0]), .pass_signed(ps_o[0]), .acc_out(acc32),
    .result_valid(rv_o[0]), .sat_flag(sat_o[0]), .term_count(cnt_o[0]));

  mac_pe #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SATURATE(1)) u_dut16s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .first(first), .last(last), .signed_mode(signed_mode),
    .a_out(a_o[1]), .b_out(b_o[1]), .pass_valid(pv_o[1]), .pass_first(pf_o[1]),
    .pass_last(pl_o[1]), .pass_signed(ps_o[1]), .acc_out(acc16s),
    .result_valid(rv_o[1]), .sat_flag(sat_o[1]), .term_count(cnt_o[1]));

  mac_pe #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SATURATE(0)) u_dut16w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .first(first), .last(last), .signed_mode(signed_mode),
    .a_out(a_o[2]), .b_out(b_o[2]), .pass_valid(pv_o[2]), .pass_first(pf_o[2]),
    .pass_last(pl_o[2]), .pass_signed(ps_o[2]), .acc_out(acc16w),
    .result_valid(rv_o[2]), .sat_flag(sat_o[2]), .term_count(cnt_o[2]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         due;
    logic [7:0] a, b;
    bit         f, l, s;
  } term_t;

  term_t      pend[$];
  term_t      cur_t;
  int         cyc = 0;
  bit         model_on = 0;
  logic [7:0] e_a = '0, e_b = '0;
  bit         e_pv, e_pf, e_pl, e_ps, e_rv;
  longint     m_acc [3];
  bit         m_sat [3];
  int         m_cnt [3];

  function automatic int cfg_w(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic bit cfg_sat(input int i);
    return (i != 2);
  endfunction

  function automatic void apply(input int i, input term_t t);
    longint w_mod, p, cur, lo, hi, sum;
    w_mod = longint'(1) << cfg_w(i);
    if (t.s) p = longint'($signed(t.a)) * longint'($signed(t.b));
    else     p = longint'(t.a) * longint'(t.b);
    if (t.f) begin
      sum = p;
      m_sat[i] = 0;
      m_cnt[i] = 1;
    end else begin
      if (t.s) begin
        cur = (m_acc[i] >= w_mod / 2) ? m_acc[i] - w_mod : m_acc[i];
        lo  = -(w_mod / 2);
        hi  = w_mod / 2 - 1;
      end else begin
        cur = m_acc[i];
        lo  = 0;
        hi  = w_mod - 1;
      end
      sum = cur + p;
      if (cfg_sat(i) && (sum > hi || sum < lo)) begin
        sum = (sum > hi) ? hi : lo;
        m_sat[i] = 1;
      end
      if (m_cnt[i] < 65535) m_cnt[i]++;
    end
    m_acc[i] = ((sum % w_mod) + w_mod) % w_mod;
  endfunction

  // A term seen at a capture edge completes two edges later.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend.delete();
      e_a = '0; e_b = '0;
      e_pv = 0; e_pf = 0; e_pl = 0; e_ps = 0; e_rv = 0;
      for (int i = 0; i < 3; i++) begin
        m_acc[i] = 0; m_sat[i] = 0; m_cnt[i] = 0;
      end
      model_on = 1;
    end else begin
      e_pv = in_valid;
      if (in_valid) begin
        e_a = a_in; e_b = b_in; e_pf = first; e_pl = last; e_ps = signed_mode;
        pend.push_back('{cyc + 2, a_in, b_in, first, last, signed_mode});
      end
      e_rv = 0;
      if (pend.size() != 0 && pend[0].due == cyc) begin
        cur_t = pend.pop_front();
        for (int i = 0; i < 3; i++) apply(i, cur_t);
        e_rv = cur_t.l;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("a_out[%0d]", i), 64'(a_o[i]), 64'(e_a));
        chk($sformatf("b_out[%0d]", i), 64'(b_o[i]), 64'(e_b));
        chk($sformatf("pass_valid[%0d]", i), 64'(pv_o[i]), 64'(e_pv));
        chk($sformatf("pass_first[%0d]", i), 64'(pf_o[i]), 64'(e_pf));
        chk($sformatf("pass_last[%0d]", i), 64'(pl_o[i]), 64'(e_pl));
        chk($sformatf("pass_signed[%0d]", i), 64'(ps_o[i]), 64'(e_ps));
        chk($sformatf("result_valid[%0d]", i), 64'(rv_o[i]), 64'(e_rv));
        chk($sformatf("sat_flag[%0d]", i), 64'(sat_o[i]), 64'(m_sat[i]));
        chk($sformatf("term_count[%0d]", i), 64'(cnt_o[i]), 64'(m_cnt[i]));
      end
      chk("acc_out[32]", 64'(acc32), m_acc[0]);
      chk("acc_out[16s]", 64'(acc16s), m_acc[1]);
      chk("acc_out[16w]", 64'(acc16w), m_acc[2]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input bit v, input logic [7:0] a, input logic [7:0] b,
                     input bit f, input bit l, input bit s);
    @(posedge clk);
    #1;
    in_valid = v; a_in = a; b_in = b; first = f; last = l; signed_mode = s;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 8'h5A, 8'hA5, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("lit reset acc", 64'(acc32), 64'd0);
    chk("lit reset rv", 64'(rv_o[0]), 64'd0);
    chk("lit reset cnt", 64'(cnt_o[0]), 64'd0);
    chk("lit reset pass_valid", 64'(pv_o[0]), 64'd0);

    // No preceding first: accumulates onto zero.
    put(1, 8'd2, 8'd3, 0, 1, 0);
    idle(3); @(negedge clk);
    chk("lit nofirst acc", 64'(acc32), 64'd6);
    chk("lit nofirst cnt", 64'(cnt_o[0]), 64'd1);

    // Unsigned three-term dot product.
    put(1, 8'd3, 8'd4, 1, 0, 0);
    put(1, 8'd5, 8'd6, 0, 0, 0);
    put(1, 8'd7, 8'd8, 0, 1, 0);
    idle(3); @(negedge clk);
    chk("lit dot acc", 64'(acc32), 64'd98);
    chk("lit dot rv", 64'(rv_o[0]), 64'd1);
    chk("lit dot cnt", 64'(cnt_o[0]), 64'd3);
    chk("lit dot sat", 64'(sat_o[0]), 64'd0);
    idle(1); @(negedge clk);
    chk("lit dot rv drop", 64'(rv_o[0]), 64'd0);
    chk("lit dot hold", 64'(acc32), 64'd98);

    // Signed single term.
    put(1, 8'h80, 8'h7F, 1, 1, 1);
    idle(3); @(negedge clk);
    chk("lit signed acc32", 64'(acc32), 64'hFFFF_C080);
    chk("lit signed acc16", 64'(acc16s), 64'hC080);
    chk("lit signed rv", 64'(rv_o[0]), 64'd1);

    // Signed saturation at 16 bits, wrap when saturation is off.
    put(1, 8'd127, 8'd127, 1, 0, 1);
    put(1, 8'd127, 8'd127, 0, 0, 1);
    put(1, 8'd127, 8'd127, 0, 0, 1);
    put(1, 8'd127, 8'd127, 0, 1, 1);
    idle(3); @(negedge clk);
    chk("lit ssat acc16s", 64'(acc16s), 64'h7FFF);
    chk("lit ssat flag16s", 64'(sat_o[1]), 64'd1);
    chk("lit ssat cnt16s", 64'(cnt_o[1]), 64'd4);
    chk("lit ssat acc16w", 64'(acc16w), 64'hFC04);
    chk("lit ssat flag16w", 64'(sat_o[2]), 64'd0);
    chk("lit ssat acc32", 64'(acc32), 64'd64516);
    put(1, 8'd1, 8'd1, 1, 1, 1);
    idle(3); @(negedge clk);
    chk("lit ssat clear", 64'(sat_o[1]), 64'd0);
    chk("lit ssat clear acc", 64'(acc16s), 64'd1);

    // Bubble inside a frame, then a back-to-back single-term frame.
    put(1, 8'd1, 8'd1, 1, 0, 0);
    idle(1);
    put(1, 8'd2, 8'd2, 0, 1, 0);
    put(1, 8'd3, 8'd3, 1, 1, 0);
    @(negedge clk);
    chk("lit fwd a_out", 64'(a_o[0]), 64'd2);
    idle(2); @(negedge clk);
    chk("lit frame1 acc", 64'(acc32), 64'd5);
    chk("lit frame1 rv", 64'(rv_o[0]), 64'd1);
    idle(1); @(negedge clk);
    chk("lit frame2 acc", 64'(acc32), 64'd9);
    chk("lit frame2 rv", 64'(rv_o[0]), 64'd1);

    // Reset with a frame in flight.
    put(1, 8'd1, 8'd1, 1, 0, 0);
    put(1, 8'd2, 8'd2, 0, 0, 0);
    @(posedge clk); #1; reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("lit rst acc", 64'(acc32), 64'd0);
    chk("lit rst a_out", 64'(a_o[0]), 64'd0);
    chk("lit rst cnt", 64'(cnt_o[0]), 64'd0);
    chk("lit rst rv", 64'(rv_o[0]), 64'd0);
    idle(3);
    put(1, 8'd4, 8'd4, 1, 1, 0);
    idle(3); @(negedge clk);
    chk("lit post-rst acc", 64'(acc32), 64'd16);
    chk("lit post-rst rv", 64'(rv_o[0]), 64'd1);

    // Unsigned maximum operands at 16 bits.
    put(1, 8'd255, 8'd255, 1, 0, 0);
    put(1, 8'd255, 8'd255, 0, 1, 0);
    idle(3); @(negedge clk);
    chk("lit umax acc16s", 64'(acc16s), 64'hFFFF);
    chk("lit umax flag16s", 64'(sat_o[1]), 64'd1);
    chk("lit umax cnt16s", 64'(cnt_o[1]), 64'd2);
    chk("lit umax acc16w", 64'(acc16w), 64'hFC02);
    chk("lit umax acc32", 64'(acc32), 64'd130050);

    // Mixed modes: a negative signed start then an unsigned term overflows unsigned range.
    put(1, 8'hFE, 8'd2, 1, 0, 1);
    put(1, 8'd3, 8'd3, 0, 1, 0);
    idle(3); @(negedge clk);
    chk("lit mixed acc32", 64'(acc32), 64'hFFFF_FFFF);
    chk("lit mixed flag32", 64'(sat_o[0]), 64'd1);
    chk("lit mixed acc16w", 64'(acc16w), 64'd5);

    idle(4);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
